// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Opcodes, state encodings and control-vector layout for the
//               multi-cycle MIPS main control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    localparam int CTRL_USED_W    = 17;
    localparam int CB_REGWRITE    = 0;
    localparam int CB_MEMTOREG    = 1;
    localparam int CB_MEMREAD     = 2;
    localparam int CB_MEMWRITE    = 3;
    localparam int CB_ALUOP_LO    = 4;
    localparam int CB_ALUSRC      = 6;
    localparam int CB_REGDST      = 7;
    localparam int CB_PCWRITE     = 8;
    localparam int CB_PCWRITECOND = 9;
    localparam int CB_IRWRITE     = 10;
    localparam int CB_IORD        = 11;
    localparam int CB_ALUSRCA     = 12;
    localparam int CB_SRCB_LO     = 13;
    localparam int CB_PCSRC_LO    = 15;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_decode
// Description : Combinational state -> control vector decode. MEM_WAIT_EN
//               gates PCWrite/IRWrite and the sw retire on mem_ready_i.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int CTRL_W = 32
) (
    input  logic [3:0]        state_i,
    input  logic [OP_W-1:0]   op_q_i,
    input  logic              mem_ready_i,
    output logic [CTRL_W-1:0] control_o,
    output logic              instr_done_o,
    output logic              illegal_o
);

    logic                   w_rdy;
    logic [CTRL_USED_W-1:0] w_ctrl;

`ifdef MEM_WAIT_EN
    assign w_rdy = mem_ready_i;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = mem_ready_i;
    assign w_rdy        = 1'b1;
`endif

    always_comb begin
        w_ctrl       = '0;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        case (state_i)
            S_FETCH: begin
                w_ctrl[CB_MEMREAD]             = 1'b1;
                w_ctrl[CB_IRWRITE]             = w_rdy;
                w_ctrl[CB_PCWRITE]             = w_rdy;
                w_ctrl[CB_SRCB_LO +: 2]        = SRCB_FOUR;
                w_ctrl[CB_ALUOP_LO +: 2]       = ALUOP_ADD;
            end
            S_DECODE: begin
                w_ctrl[CB_SRCB_LO +: 2]        = SRCB_BOFF;
                w_ctrl[CB_ALUOP_LO +: 2]       = ALUOP_ADD;
            end
            S_MEMADR: begin
                w_ctrl[CB_ALUSRCA]             = 1'b1;
                w_ctrl[CB_SRCB_LO +: 2]        = SRCB_IMM;
                w_ctrl[CB_ALUOP_LO +: 2]       = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctrl[CB_MEMREAD]             = 1'b1;
                w_ctrl[CB_IORD]                = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl[CB_REGWRITE]            = 1'b1;
                w_ctrl[CB_MEMTOREG]            = 1'b1;
                instr_done_o                   = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl[CB_MEMWRITE]            = 1'b1;
                w_ctrl[CB_IORD]                = 1'b1;
                instr_done_o                   = w_rdy;
            end
            S_REXEC: begin
                w_ctrl[CB_ALUSRCA]             = 1'b1;
                w_ctrl[CB_ALUOP_LO +: 2]       = ALUOP_FUNCT;
            end
            S_RWB: begin
                w_ctrl[CB_REGDST]              = 1'b1;
                w_ctrl[CB_REGWRITE]            = 1'b1;
                instr_done_o                   = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl[CB_ALUSRCA]             = 1'b1;
                w_ctrl[CB_ALUOP_LO +: 2]       = ALUOP_SUB;
                w_ctrl[CB_PCWRITECOND]         = 1'b1;
                w_ctrl[CB_PCSRC_LO +: 2]       = PCSRC_ALUOUT;
                instr_done_o                   = 1'b1;
            end
            S_JUMP: begin
                w_ctrl[CB_PCWRITE]             = 1'b1;
                w_ctrl[CB_PCSRC_LO +: 2]       = PCSRC_JUMP;
                instr_done_o                   = 1'b1;
            end
            S_IEXEC: begin
                w_ctrl[CB_ALUSRCA]             = 1'b1;
                w_ctrl[CB_SRCB_LO +: 2]        = SRCB_IMM;
                w_ctrl[CB_ALUOP_LO +: 2]       = (op_q_i == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            S_IWB: begin
                w_ctrl[CB_REGWRITE]            = 1'b1;
                instr_done_o                   = 1'b1;
            end
            S_TRAP: begin
                illegal_o                      = 1'b1;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
        // ALUSrc mirrors the immediate selection on the B operand mux
        w_ctrl[CB_ALUSRC] = (w_ctrl[CB_SRCB_LO +: 2] == SRCB_IMM);
    end

    generate
        if (CTRL_W > CTRL_USED_W) begin : g_pad
            assign control_o = {{(CTRL_W - CTRL_USED_W){1'b0}}, w_ctrl};
        end else begin : g_nopad
            assign control_o = w_ctrl;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle MIPS main control FSM with retire counter and
//               illegal-opcode trap. Optional MEM_WAIT_EN adds memory stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic              mem_ready_i,
    output logic [CTRL_W-1:0] control_o,
    output logic [3:0]        state_o,
    output logic              instr_done_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  instr_cnt_o
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              w_rdy;

`ifdef MEM_WAIT_EN
    assign w_rdy = mem_ready_i;
`else
    assign w_rdy = 1'b1;
`endif

    mc_ctrl_decode #(
        .OP_W   (OP_W),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .state_i      (state_q),
        .op_q_i       (op_q),
        .mem_ready_i  (mem_ready_i),
        .control_o    (control_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_FETCH;
            S_FETCH:  if (w_rdy) state_d = S_DECODE;
            S_DECODE: begin
                op_d = op_i;
                case (op_i)
                    OP_RTYPE:        state_d = S_REXEC;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ORI: state_d = S_IEXEC;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (w_rdy) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (w_rdy) state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Retire count follows the decoded done pulse, so stalled stores do not count early
    always_comb begin
        cnt_d = instr_done_o ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o     = state_q;
    assign instr_cnt_o = cnt_q;

endmodule
`default_nettype wire
